// File: rtl/and2_chk_pkg.sv
// Shared types and constants for the and2 stimulus/response checker.
// Holds the FSM encoding, LFSR taps, index width and the expected-value pipeline entry.
package and2_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int IDX_W = 16;

    localparam logic [IDX_W-1:0] FIRST_ERR_NONE = 16'hFFFF;

    typedef struct packed {
        logic             vld;
        logic             exp;
`ifdef AND2_CHK_FIRST_ERR_EN
        logic [IDX_W-1:0] idx;
`endif
    } pipe_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/and2_chk_lfsr.sv
// 8-bit Galois LFSR with synchronous load of SEED and step enable; exposes the low two bits.
// Latency: new value visible the cycle after load/step.
// No backpressure: load has priority over step.
module and2_chk_lfsr
    import and2_chk_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    output logic [1:0] low_bits
);

    // An all-zero Galois LFSR never leaves zero, so substitute 1
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= SEED_EFF;
        end else if (load) begin
            value <= SEED_EFF;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

    assign low_bits = value[1:0];

endmodule

// File: rtl/and2_stim_checker.sv
// Drives a/b of a registered AND DUT, predicts a&b and counts mismatches on c after LATENCY cycles.
// Latency: vector i on a/b i+1 cycles after the start edge; done rises NUM_VECTORS+LATENCY+1 cycles after it.
// No backpressure: start is honoured only in IDLE/DONE. AND2_CHK_FIRST_ERR_EN adds first_err_idx.
module and2_stim_checker
    import and2_chk_pkg::*;
#(
    parameter int         NUM_VECTORS = 256,
    parameter int         LATENCY     = 1,
    parameter int         ERR_W       = 8,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef AND2_CHK_FIRST_ERR_EN
    ,
    output logic [IDX_W-1:0] first_err_idx
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
    localparam logic [IDX_W-1:0] EXH_END    = IDX_W'(4);
    localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       drain_cnt;
    logic             last_vec;
    logic             start_ok;
    logic             lfsr_step;
    logic             clr;
    logic [1:0]       lfsr_ab;
    logic [1:0]       vec_ab;
    logic             vec_vld;
`ifdef AND2_CHK_FIRST_ERR_EN
    logic [IDX_W-1:0] vec_idx;
`endif
    pipe_t            head;
    pipe_t            tail;
    pipe_t            pipe [LATENCY];
    logic             mismatch;

    assign last_vec = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last_vec) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Results clear on the first RUN cycle, not on the start edge, so a
    // back-to-back restart from DONE still shows the finished verdict while done is high.
    always_comb begin
        start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
        lfsr_step = 1'b0;
        clr       = 1'b0;
        vec_ab    = 2'b00;
        if (state == ST_RUN) begin
            vec_ab    = (idx < EXH_END) ? idx[1:0] : lfsr_ab;
            lfsr_step = (idx >= EXH_END);
            clr       = (idx == '0);
        end
    end

    and2_chk_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok),
        .step     (lfsr_step),
        .low_bits (lfsr_ab)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            idx       <= (state == ST_RUN) ? idx + IDX_W'(1) : '0;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a       <= 1'b0;
            b       <= 1'b0;
            vec_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef AND2_CHK_FIRST_ERR_EN
            vec_idx <= '0;
`endif
        end else begin
            {a, b}  <= vec_ab;
            vec_vld <= (state == ST_RUN);
            busy    <= (state == ST_RUN) || (state == ST_DRAIN);
            done    <= (state == ST_DONE);
`ifdef AND2_CHK_FIRST_ERR_EN
            vec_idx <= idx;
`endif
        end
    end

    // The registered a/b act as the stage ahead of the pipe, matching the DUT's own input register
    always_comb begin
        head     = '0;
        head.vld = vec_vld;
        head.exp = a & b;
`ifdef AND2_CHK_FIRST_ERR_EN
        head.idx = vec_idx;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= head;
            for (int k = 1; k < LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign tail     = pipe[LATENCY-1];
    assign mismatch = tail.vld && (c != tail.exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (mismatch && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef AND2_CHK_FIRST_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_err_idx <= FIRST_ERR_NONE;
        end else if (clr) begin
            first_err_idx <= FIRST_ERR_NONE;
        end else if (mismatch && (first_err_idx == FIRST_ERR_NONE)) begin
            first_err_idx <= tail.idx;
        end
    end
`endif

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_and2_stim_checker.sv
// Directed bench: several checker instances, each paired with a behavioural DUT (golden, stuck-at-0, OR, NAND, 2-cycle AND).
module tb_and2_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic start0, a0, b0, c0, busy0, done0, pass0;
    logic start1, a1, b1, c1, busy1, done1, pass1;
    logic start2, a2, b2, c2, busy2, done2, pass2;
    logic start3, a3, b3, c3, busy3, done3, pass3;
    logic start4, a4, b4, c4, busy4, done4, pass4, p4;
    logic [7:0] err0, err1, err2, err4;
    logic [1:0] err3;
`ifdef AND2_CHK_FIRST_ERR_EN
    logic [15:0] fe0, fe1, fe2, fe3, fe4;
`endif

    // Hand-derived: indices 0..3 exhaustive, then LFSR[1:0] from seed A5 (A5,EA,75,82,41,98,4C,26,13,B1,E0,70)
    logic [1:0] ab_exp [16] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10,
                                2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [1:0] run1 [8];
    int n;

    and2_stim_checker #(.NUM_VECTORS(16), .LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef AND2_CHK_FIRST_ERR_EN
        , .first_err_idx(fe0)
`endif
    );
    and2_stim_checker #(.NUM_VECTORS(4), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef AND2_CHK_FIRST_ERR_EN
        , .first_err_idx(fe1)
`endif
    );
    and2_stim_checker #(.NUM_VECTORS(4), .LATENCY(1)) u2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef AND2_CHK_FIRST_ERR_EN
        , .first_err_idx(fe2)
`endif
    );
    and2_stim_checker #(.NUM_VECTORS(16), .LATENCY(1), .ERR_W(2)) u3 (
        .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .c(c3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef AND2_CHK_FIRST_ERR_EN
        , .first_err_idx(fe3)
`endif
    );
    and2_stim_checker #(.NUM_VECTORS(8), .LATENCY(2)) u4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .c(c4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4)
`ifdef AND2_CHK_FIRST_ERR_EN
        , .first_err_idx(fe4)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c0 <= 1'b0; c1 <= 1'b0; c2 <= 1'b0; c3 <= 1'b0; c4 <= 1'b0; p4 <= 1'b0;
        end else begin
            c0 <= a0 & b0;
            c1 <= 1'b0;
            c2 <= a2 | b2;
            c3 <= ~(a3 & b3);
            p4 <= a4 & b4;
            c4 <= p4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {start0, start1, start2, start3, start4} = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_ab", {a0, b0}, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
`ifdef AND2_CHK_FIRST_ERR_EN
        chk("rst_fe", fe0, 16'hFFFF);
`endif
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Golden run, 16 vectors, latency 1
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("u0_busy_at_start", busy0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("u0_ab[%0d]", i), {a0, b0}, ab_exp[i]);
            chk($sformatf("u0_busy[%0d]", i), busy0, 1);
        end
        n = 16;
        while (!done0 && n < 60) begin
            tick();
            n++;
        end
        chk("u0_done_latency", n, 18);
        chk("u0_pass", pass0, 1);
        chk("u0_err", err0, 0);
        chk("u0_busy_done", busy0, 0);
        chk("u0_ab_idle", {a0, b0}, 0);
`ifdef AND2_CHK_FIRST_ERR_EN
        chk("u0_fe", fe0, 16'hFFFF);
`endif
        tick();
        chk("u0_done_hold", done0, 1);

        // Faulty DUTs: stuck-at-0, OR, NAND with saturating 2-bit counter
        {start1, start2, start3} = 3'b111;
        tick();
        {start1, start2, start3} = 3'b000;
        repeat (20) tick();
        chk("u1_done", done1, 1);
        chk("u1_err", err1, 1);
        chk("u1_pass", pass1, 0);
        chk("u2_done", done2, 1);
        chk("u2_err", err2, 2);
        chk("u2_pass", pass2, 0);
        chk("u3_done", done3, 1);
        chk("u3_err_sat", err3, 3);
        chk("u3_pass", pass3, 0);
`ifdef AND2_CHK_FIRST_ERR_EN
        chk("u1_fe", fe1, 3);
        chk("u2_fe", fe2, 1);
        chk("u3_fe", fe3, 0);
`endif

        // start held high, 8 vectors, latency 2: done for one cycle, then an identical rerun
        start4 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            run1[i] = {a4, b4};
            chk($sformatf("u4_ab[%0d]", i), {a4, b4}, ab_exp[i]);
            chk($sformatf("u4_busy[%0d]", i), busy4, 1);
        end
        tick();
        chk("u4_busy_drain1", busy4, 1);
        chk("u4_done_drain1", done4, 0);
        tick();
        chk("u4_busy_drain2", busy4, 1);
        chk("u4_done_drain2", done4, 0);
        tick();
        chk("u4_done_rise", done4, 1);
        chk("u4_pass", pass4, 1);
        chk("u4_busy_fall", busy4, 0);
        tick();
        start4 = 1'b0;
        chk("u4_done_one_cycle", done4, 0);
        chk("u4_busy_restart", busy4, 1);
        chk("u4_err_cleared", err4, 0);
        chk("u4_rerun_ab[0]", {a4, b4}, run1[0]);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("u4_rerun_ab[%0d]", i), {a4, b4}, run1[i]);
        end
        n = 19;
        while (!done4 && n < 60) begin
            tick();
            n++;
        end
        chk("u4_rerun_done_latency", n, 22);
        chk("u4_rerun_pass", pass4, 1);

        // Reset while vector 7 is on the outputs
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        chk("u0_ab_v7", {a0, b0}, ab_exp[7]);
        chk("u0_busy_v7", busy0, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ab", {a0, b0}, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_pass", pass0, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_u4_done", done4, 0);
`ifdef AND2_CHK_FIRST_ERR_EN
        chk("midrst_fe", fe0, 16'hFFFF);
`endif
        tick();
        reset = 1'b1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 60) begin
            tick();
            n++;
        end
        chk("u0_post_rst_latency", n, 18);
        chk("u0_post_rst_pass", pass0, 1);
        chk("u0_post_rst_err", err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and2_stim_checker.md
# and2_stim_checker

Self-checking stimulus/response block for the registered 2-input AND testcase. It drives the `a`/`b` inputs of an `and2`-style DUT with a deterministic vector sequence, predicts `a & b`, and compares the prediction against the DUT's registered `c` after a configurable latency. It reports a pass/fail verdict and an error count. It sits beside the DUT in on-chip self-test wrappers.

## Interface
- `NUM_VECTORS`, 256: vectors per run; range 4..65535.
- `LATENCY`, 1: DUT cycles from `a`/`b` to `c`; range 1..8.
- `ERR_W`, 8: width of the error counter.
- `SEED`, 8'hA5: LFSR seed; the value 0 is replaced by 8'h01.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous active-low reset.
- `start`  input  1  run request, sampled only in IDLE and DONE.
- `a`  output  1  DUT input a.
- `b`  output  1  DUT input b.
- `c`  input  1  DUT registered output.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  high in DONE.
- `pass`  output  1  `done && err_count == 0`.
- `err_count`  output  ERR_W  count of mismatches; saturates.
- `first_err_idx`  output  16  present only with `AND2_CHK_FIRST_ERR_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after vector `NUM_VECTORS-1` is driven.
  - DRAIN → DONE after `LATENCY` cycles.
  - DONE → RUN on `start`. Otherwise DONE holds and the results stay stable.
- On entering RUN:
  - Vector index, `err_count` and `first_err_idx` clear.
  - The LFSR reloads `SEED`.
- Vector sequence:
  - Indices 0..3 are exhaustive: {a,b} = 00, 01, 10, 11.
  - Index ≥4: {a,b} = LFSR[1:0], and the LFSR steps once per vector.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It steps only while index ≥4.
- Expected-value pipeline:
  - Depth `LATENCY`.
  - Each entry holds {valid, exp = a&b, idx}.
  - Entries are tagged valid only for vectors driven in RUN.
- Compare: when the pipeline output is valid and `c != exp`, `err_count` increments. It saturates at 2^ERR_W−1.
- In IDLE, DRAIN and DONE, `a` = `b` = 0.
- `start` during RUN or DRAIN is ignored.
- Reset values (asserted asynchronously):
  - State IDLE.
  - `a`, `b`, `busy`, `done`, `pass` = 0.
  - `err_count` = 0, `first_err_idx` = 16'hFFFF.
  - Pipeline valids cleared.
- Reset mid-run aborts the run. No partial verdict is kept.

## Timing
- `a`/`b` are registered outputs. Vector i appears on the outputs i+1 cycles after the edge that samples `start`.
- `c` for vector i is compared at the edge `LATENCY` cycles after vector i appears.
- `busy` rises with vector 0 and falls when `done` rises.
- `done` rises `NUM_VECTORS + LATENCY + 1` cycles after the `start` edge.
- `pass` and `err_count` are final when `done` rises.
- A mismatch on the last vector is counted before `done` rises.

## Configuration
- `AND2_CHK_FIRST_ERR_EN` defined:
  - The `first_err_idx` port exists.
  - It captures the index of the first mismatching vector of the run.
  - It holds 16'hFFFF if the run has no mismatch.
  - The index is carried in the pipeline.
- `AND2_CHK_FIRST_ERR_EN` undefined:
  - The port and the idx pipeline field are absent.
  - All other behaviour is identical.

## Structure
- Package `and2_chk_pkg` holds:
  - the state enum;
  - the LFSR tap constant 8'hB8;
  - `IDX_W` = 16;
  - the `FIRST_ERR_NONE` = 16'hFFFF constant.
- Sub-module `and2_chk_lfsr`: the 8-bit Galois LFSR with load and step enables.

## Test plan
- Golden DUT (registered AND), `NUM_VECTORS`=16, `LATENCY`=1, single `start` pulse → `done` 18 cycles after `start`, `pass`=1, `err_count`=0, `first_err_idx`=16'hFFFF.
- DUT `c` stuck at 0, `NUM_VECTORS`=4 → `err_count`=1, `first_err_idx`=3, `pass`=0.
- DUT computes registered `a|b`, `NUM_VECTORS`=4 → `err_count`=2, `first_err_idx`=1.
- `ERR_W`=2, DUT output registered `~(a&b)`, `NUM_VECTORS`=16 → `err_count` saturates at 3, `pass`=0.
- `reset` pulled low at vector 7 of a golden run → all outputs at reset values within the same cycle; a later `start` gives `pass`=1 with full timing.
- `start` held high throughout, `NUM_VECTORS`=8, `LATENCY`=2:
  - `start` is ignored during RUN/DRAIN;
  - `done` lasts 1 cycle, then RUN restarts with counters cleared;
  - the second run reproduces the identical `a`/`b` sequence.
